// File: rtl/aes_axis_pkg.sv
// aes_axis_pkg: widths, FSM states and beat counts shared by the AES AXI-Stream front end
`ifndef WORD_S
`define WORD_S 32
`endif
`ifndef BLK_S
`define BLK_S 128
`endif
`ifndef KEY_S
`define KEY_S 128
`endif
package aes_axis_pkg;
  localparam int WORD_W = `WORD_S;
  localparam int BLK_W = `BLK_S;
  localparam int KEY_W = `KEY_S;
  localparam int BEATS_PER_BLK = BLK_W / WORD_W;
  localparam int BEATS_PER_KEY = KEY_W / WORD_W;
  localparam logic [1:0] LAST_BLK_BEAT = 2'(BEATS_PER_BLK - 1);
  localparam logic [1:0] LAST_KEY_BEAT = 2'(BEATS_PER_KEY - 1);
  typedef enum logic [1:0] {S_BLK, S_KEY, S_OUT} state_t;
endpackage

// File: rtl/aes_word_shreg.sv
// aes_word_shreg: load-enabled shift-in register, first word shifted in ends up in the top slot
module aes_word_shreg #(
  parameter int W = 32,
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           en,
  input  logic [W-1:0]   d,
  output logic [W*N-1:0] q
);
  always_ff @(posedge clock) begin
    if (reset) q <= '0;
    else if (en) q <= {q[W*(N-1)-1:0], d};
  end
endmodule

// File: rtl/aes_axis_rx_frontend.sv
// aes_axis_rx_frontend: AXI-Stream beats -> AES block/key; define AES_AXIS_KEY_REUSE_EN to allow 4-beat frames reusing the cached key
module aes_axis_rx_frontend
  import aes_axis_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [WORD_W-1:0] s00_axis_tdata,
  input  logic              s00_axis_tvalid,
  input  logic              s00_axis_tlast,
  output logic              s00_axis_tready,
  output logic [BLK_W-1:0]  blk_o,
  output logic [KEY_W-1:0]  key_o,
  output logic              key_new_o,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_o
);
`ifdef AES_AXIS_KEY_REUSE_EN
  localparam bit REUSE_EN = 1'b1;
`else
  localparam bit REUSE_EN = 1'b0;
`endif
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic key_valid, key_valid_n, key_new_n, key_load, err_n, acc;
  logic [KEY_W-1:0] key_sh;
  assign s00_axis_tready = state != S_OUT;
  assign out_valid = state == S_OUT;
  assign acc = s00_axis_tvalid & s00_axis_tready;
  aes_word_shreg #(.W(WORD_W), .N(BEATS_PER_BLK)) u_blk (
    .clock, .reset, .en(acc & (state == S_BLK)), .d(s00_axis_tdata), .q(blk_o)
  );
  aes_word_shreg #(.W(WORD_W), .N(BEATS_PER_KEY)) u_key (
    .clock, .reset, .en(acc & (state == S_KEY)), .d(s00_axis_tdata), .q(key_sh)
  );
  // the 2-bit counter wraps to 0 on each state's last beat, so no explicit clear is needed there
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    key_valid_n = key_valid;
    key_new_n = key_new_o;
    key_load = 1'b0;
    err_n = 1'b0;
    if (acc) begin
      cnt_n = cnt + 2'd1;
      if (state == S_BLK && cnt == LAST_BLK_BEAT && !s00_axis_tlast) state_n = S_KEY;
      else if (state == S_BLK && cnt == LAST_BLK_BEAT && REUSE_EN && key_valid) begin
        state_n = S_OUT;
        key_new_n = 1'b0;
      end else if (state == S_KEY && cnt == LAST_KEY_BEAT) begin
        state_n = S_OUT;
        key_load = 1'b1;
        key_valid_n = 1'b1;
        key_new_n = 1'b1;
      end else if (s00_axis_tlast) begin
        state_n = S_BLK;
        cnt_n = '0;
        err_n = 1'b1;
      end
    end
    if (out_valid && out_ready) state_n = S_BLK;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_BLK;
      cnt <= '0;
      key_valid <= 1'b0;
      key_new_o <= 1'b0;
      err_o <= 1'b0;
      key_o <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      key_valid <= key_valid_n;
      key_new_o <= key_new_n;
      err_o <= err_n;
      if (key_load) key_o <= {key_sh[KEY_W-WORD_W-1:0], s00_axis_tdata};
    end
  end
endmodule

// File: tb/tb_aes_axis_rx_frontend.sv
// tb_aes_axis_rx_frontend: directed and random frames checked against a frame-level model of the front end
module tb_aes_axis_rx_frontend;
  logic clock = 1'b0, reset = 1'b1;
  logic [31:0] s00_axis_tdata = '0;
  logic s00_axis_tvalid = 1'b0, s00_axis_tlast = 1'b0, s00_axis_tready;
  logic [127:0] blk_o, key_o;
  logic key_new_o, out_valid, err_o;
  logic out_ready = 1'b1;
`ifdef AES_AXIS_KEY_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif
  int n_cmp = 0, n_fail = 0, cyc = 0;
  bit stall = 1'b0, osc = 1'b0;
  typedef struct packed {logic [127:0] blk; logic [127:0] key; logic nw;} exp_t;
  exp_t exp_q[$];
  logic [31:0] fb[$];
  logic [127:0] ck;
  bit kv = 1'b0, due = 1'b0, pend = 1'b0;

  aes_axis_rx_frontend dut (
    .clock(clock), .reset(reset),
    .s00_axis_tdata(s00_axis_tdata), .s00_axis_tvalid(s00_axis_tvalid),
    .s00_axis_tlast(s00_axis_tlast), .s00_axis_tready(s00_axis_tready),
    .blk_o(blk_o), .key_o(key_o), .key_new_o(key_new_o),
    .out_valid(out_valid), .out_ready(out_ready), .err_o(err_o)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    #1;
    out_ready = stall ? 1'b0 : osc ? ((cyc % 8) >= 2) : 1'b1;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // frame-level model: collect accepted beats and decide per frame what the core must see
  always @(negedge clock) begin
    logic [127:0] b;
    if (reset) begin
      fb.delete();
      exp_q.delete();
      kv = 1'b0;
      due = 1'b0;
      pend = 1'b0;
    end else begin
      check("tready_vs_out_valid", s00_axis_tready, !out_valid);
      check("err_pulse", err_o, pend);
      pend = 1'b0;
      if (due) check("out_latency", out_valid, 1);
      due = 1'b0;
      if (out_valid) begin
        if (exp_q.size() == 0) check("spurious_out", out_valid, 0);
        else begin
          check("out_blk", blk_o, exp_q[0].blk);
          check("out_key", key_o, exp_q[0].key);
          check("out_key_new", key_new_o, exp_q[0].nw);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (s00_axis_tvalid && s00_axis_tready) begin
        fb.push_back(s00_axis_tdata);
        if (fb.size() == 8) begin
          b = {fb[0], fb[1], fb[2], fb[3]};
          ck = {fb[4], fb[5], fb[6], fb[7]};
          kv = 1'b1;
          exp_q.push_back('{blk: b, key: ck, nw: 1'b1});
          due = 1'b1;
          fb.delete();
        end else if (s00_axis_tlast) begin
          if (fb.size() == 4 && REUSE && kv) begin
            b = {fb[0], fb[1], fb[2], fb[3]};
            exp_q.push_back('{blk: b, key: ck, nw: 1'b0});
            due = 1'b1;
          end else pend = 1'b1;
          fb.delete();
        end
      end
    end
  end

  task automatic idle(input int n);
    s00_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int t;
    s00_axis_tvalid = 1'b1;
    s00_axis_tdata = d;
    s00_axis_tlast = l;
    for (t = 0; t < 200; t++) begin
      @(negedge clock);
      if (s00_axis_tready) break;
    end
    if (t == 200) check("send_timeout", 0, 1);
    @(posedge clock);
    #1;
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w[8], input int n, input int last_at, input int maxgap);
    for (int i = 0; i < n; i++) begin
      if (maxgap > 0) idle($urandom_range(0, maxgap));
      send(w[i], i == last_at);
    end
  endtask

  task automatic wait_out(output logic v, output logic [127:0] b, output logic [127:0] k, output logic nw);
    v = 1'b0;
    for (int i = 0; i < 50 && !v; i++) begin
      @(negedge clock);
      v = out_valid;
      b = blk_o;
      k = key_o;
      nw = key_new_o;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wait_err(output logic e);
    e = 1'b0;
    for (int i = 0; i < 4 && !e; i++) begin
      @(negedge clock);
      e = err_o;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] t1[8] = '{32'h54776F20, 32'h4F6E6520, 32'h4E696E65, 32'h2054776F,
                           32'h54686174, 32'h73206D79, 32'h204B756E, 32'h67204675};
    logic [31:0] t2[8] = '{32'h12345678, 32'h91112345, 32'h67890123, 32'h45678901, 0, 0, 0, 0};
    logic [31:0] f3[8] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                           32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    logic [31:0] e4[8] = '{32'hAAAA0000, 32'hBBBB1111, 0, 0, 0, 0, 0, 0};
    logic [31:0] rw[8];
    logic v, nw, e;
    logic [127:0] b, k;
    int r, last, n;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_tready", s00_axis_tready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_err", err_o, 0);
    check("rst_key_new", key_new_o, 0);
    check("rst_blk", blk_o, 0);
    check("rst_key", key_o, 0);
    @(posedge clock);
    #1;
    // T1: full frame loads block and key
    send_frame(t1, 8, -1, 0);
    wait_out(v, b, k, nw);
    check("t1_valid", v, 1);
    check("t1_blk", b, 128'h54776F204F6E65204E696E652054776F);
    check("t1_key", k, 128'h5468617473206D79204B756E67204675);
    check("t1_key_new", nw, 1);
    // T2: short frame, key reuse or framing error depending on build
    send_frame(t2, 4, 3, 0);
`ifdef AES_AXIS_KEY_REUSE_EN
    wait_out(v, b, k, nw);
    check("t2_valid", v, 1);
    check("t2_blk", b, 128'h12345678911123456789012345678901);
    check("t2_key", k, 128'h5468617473206D79204B756E67204675);
    check("t2_key_new", nw, 0);
`else
    wait_err(e);
    check("t2_err", e, 1);
`endif
    idle(2);
    // T3: core stalls while the master keeps offering the next frame
    stall = 1'b1;
    send_frame(t1, 8, -1, 0);
    fork
      send_frame(f3, 8, -1, 0);
      begin
        wait_out(v, b, k, nw);
        check("t3_valid", v, 1);
        repeat (5) begin
          @(negedge clock);
          check("t3_tready", s00_axis_tready, 0);
          check("t3_blk_hold", blk_o, 128'h54776F204F6E65204E696E652054776F);
        end
        stall = 1'b0;
      end
    join
    wait_out(v, b, k, nw);
    check("t3_next_blk", b, 128'h11111111222222223333333344444444);
    check("t3_next_key", k, 128'h55555555666666667777777788888888);
    // T4: tlast on beat 1 drops the frame and keeps the key
    send_frame(e4, 2, 1, 0);
    wait_err(e);
    check("t4_err", e, 1);
`ifdef AES_AXIS_KEY_REUSE_EN
    send_frame(t2, 4, 3, 0);
    wait_out(v, b, k, nw);
    check("t4_key_kept", k, 128'h55555555666666667777777788888888);
`endif
    send_frame(t1, 8, -1, 0);
    wait_out(v, b, k, nw);
    check("t4_after_blk", b, 128'h54776F204F6E65204E696E652054776F);
    check("t4_after_key_new", nw, 1);
    // T5: reset mid-frame clears the cached key
    send(t1[0], 1'b0);
    send(t1[1], 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("t5_rst_out_valid", out_valid, 0);
    check("t5_rst_key", key_o, 0);
    @(posedge clock);
    #1;
    send_frame(t2, 4, 3, 0);
    wait_err(e);
    check("t5_err", e, 1);
    // T6: random gaps and oscillating ready, model only
    osc = 1'b1;
    for (int f = 0; f < 50; f++) begin
      foreach (rw[j]) rw[j] = $urandom;
      r = $urandom_range(0, 99);
      if (r < 70) begin
        n = 8;
        last = $urandom_range(0, 1) ? 7 : -1;
      end else if (r < 85) begin
        n = 4;
        last = 3;
      end else begin
        last = $urandom_range(0, 5);
        last = last < 3 ? last : last + 1;
        n = last + 1;
      end
      send_frame(rw, n, last, 2);
    end
    osc = 1'b0;
    idle(20);
    check("drain_outputs", 128'(exp_q.size()), 0);
    check("drain_err", pend, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
